// File: rtl/milano_pkg.sv
// Shared types and constants for the milano data-port arbiter.
package milano_pkg;

   typedef logic [1:0] arb_state_e;

   localparam arb_state_e ARB_IDLE = 2'd0;
   localparam arb_state_e ARB_REQ  = 2'd1;
   localparam arb_state_e ARB_RESP = 2'd2;

   localparam int unsigned ARB_TIMEOUT_DEF = 16;

   typedef enum logic {
      ARB_M0 = 1'b0,
      ARB_M1 = 1'b1
   } arb_master_e;

endpackage

// File: rtl/milano_data_arb_if.sv
// req/gnt/rvalid memory bus bundle; master drives the request, slave answers.
interface milano_data_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic                  req;
   logic [ADDR_W-1:0]     addr;
   logic                  we;
   logic [DATA_W/8-1:0]   be;
   logic [DATA_W-1:0]     wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/milano_arb_pick.sv
// Combinational winner selection for the two-master data arbiter.
// MILANO_DATA_ARB_RR_EN selects round-robin ties; otherwise master 0 has fixed priority.
module milano_arb_pick
   import milano_pkg::*;
(
   input  logic        req0_i,
   input  logic        req1_i,
   input  arb_master_e last_i,
   output logic        valid_o,
   output arb_master_e winner_o
);

`ifndef MILANO_DATA_ARB_RR_EN
   logic unused_last;
   assign unused_last = last_i;
`endif

   always_comb begin
      valid_o  = req0_i | req1_i;
      winner_o = ARB_M0;
      if (req0_i && req1_i) begin
`ifdef MILANO_DATA_ARB_RR_EN
         winner_o = (last_i == ARB_M0) ? ARB_M1 : ARB_M0;
`else
         winner_o = ARB_M0;
`endif
      end else if (req1_i) begin
         winner_o = ARB_M1;
      end
   end

endmodule

// File: rtl/milano_data_arb.sv
// Two-master arbiter for the milano data port: one outstanding access, response watchdog.
// Tie-break policy set by MILANO_DATA_ARB_RR_EN (see milano_arb_pick).
module milano_data_arb
   import milano_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   milano_data_arb_if.slave   m0,
   milano_data_arb_if.slave   m1,
   milano_data_arb_if.master  data,
   output logic               err_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned BE_W  = DATA_W / 8;

   arb_state_e        state_q, state_d;
   arb_master_e       owner_q, owner_d;
   arb_master_e       last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_d;

   logic              pick_valid;
   arb_master_e       pick_winner;

   logic              own_req;
   logic [ADDR_W-1:0] own_addr;
   logic              own_we;
   logic [BE_W-1:0]   own_be;
   logic [DATA_W-1:0] own_wdata;

   milano_arb_pick u_pick (
      .req0_i   (m0.req),
      .req1_i   (m1.req),
      .last_i   (last_q),
      .valid_o  (pick_valid),
      .winner_o (pick_winner)
   );

   // Live request of the current owner; only forwarded to the slave while in REQ.
   always_comb begin
      if (owner_q == ARB_M1) begin
         own_req   = m1.req;
         own_addr  = m1.addr;
         own_we    = m1.we;
         own_be    = m1.be;
         own_wdata = m1.wdata;
      end else begin
         own_req   = m0.req;
         own_addr  = m0.addr;
         own_we    = m0.we;
         own_be    = m0.be;
         own_wdata = m0.wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      err_d   = err_o;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               owner_d = pick_winner;
               state_d = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (!own_req) begin
               state_d = ARB_IDLE;
            end else if (data.gnt) begin
               last_d  = owner_q;
               cnt_d   = '0;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (data.rvalid) begin
               state_d = ARB_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ARB_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // A response with nothing outstanding is a slave protocol error.
      if (data.rvalid && (state_q != ARB_RESP)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_M0;
         last_q  <= ARB_M1;
         cnt_q   <= '0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_o   <= err_d;
      end
   end

   always_comb begin
      data.req   = 1'b0;
      data.addr  = '0;
      data.we    = 1'b0;
      data.be    = '0;
      data.wdata = '0;
      m0.gnt     = 1'b0;
      m1.gnt     = 1'b0;
      m0.rvalid  = 1'b0;
      m1.rvalid  = 1'b0;
      if (state_q == ARB_REQ) begin
         data.req   = own_req;
         data.addr  = own_addr;
         data.we    = own_we;
         data.be    = own_be;
         data.wdata = own_wdata;
         if (owner_q == ARB_M1) begin
            m1.gnt = data.gnt & own_req;
         end else begin
            m0.gnt = data.gnt & own_req;
         end
      end
      if (state_q == ARB_RESP) begin
         if (owner_q == ARB_M1) begin
            m1.rvalid = data.rvalid;
         end else begin
            m0.rvalid = data.rvalid;
         end
      end
   end

   assign m0.rdata = data.rdata;
   assign m1.rdata = data.rdata;

endmodule

// File: tb/tb_milano_data_arb.sv
// Directed, scoreboard-checked bench for milano_data_arb.
module tb_milano_data_arb;
   import milano_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic err;

   always #5 clk = ~clk;

   milano_data_arb_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
   milano_data_arb_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
   milano_data_arb_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();

   milano_data_arb #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .m0    (m0_bus),
      .m1    (m1_bus),
      .data  (data_bus),
      .err_o (err)
   );

   typedef struct {
      int          m;
      logic [31:0] rdata;
   } resp_t;

   resp_t sb_q[$];
   int    pass_cnt = 0;
   int    fail_cnt = 0;
   int    total_cnt = 0;
   bit    last_m = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input bit r0, input bit r1);
      if (r0 && r1) begin
`ifdef MILANO_DATA_ARB_RR_EN
         return last_m ? 0 : 1;
`else
         return 0;
`endif
      end
      return r1 ? 1 : 0;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dreq"}, data_bus.req, 0);
      chk({tag, "_daddr"}, data_bus.addr, 0);
      chk({tag, "_dwe"}, data_bus.we, 0);
      chk({tag, "_dbe"}, data_bus.be, 0);
      chk({tag, "_dwdata"}, data_bus.wdata, 0);
      chk({tag, "_gnt"}, {m0_bus.gnt, m1_bus.gnt}, 0);
      chk({tag, "_rvalid"}, {m0_bus.rvalid, m1_bus.rvalid}, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      last_m = 1'b1;
   endtask

   // Slave returns rvalid; expectation is queued, then popped on the DUT's rvalid.
   task automatic slave_rvalid(input logic [31:0] rd, input int exp_m);
      resp_t e;
      sb_q.push_back('{m: exp_m, rdata: rd});
      data_bus.rvalid = 1'b1;
      data_bus.rdata  = rd;
      #1;
      chk("rvalid_seen", m0_bus.rvalid | m1_bus.rvalid, 1);
      if (m0_bus.rvalid || m1_bus.rvalid) begin
         e = sb_q.pop_front();
         chk("rvalid_m0", m0_bus.rvalid, e.m == 0);
         chk("rvalid_m1", m1_bus.rvalid, e.m == 1);
         chk("rdata", (e.m == 1) ? m1_bus.rdata : m0_bus.rdata, e.rdata);
      end
   endtask

   // Entered at the start of an IDLE cycle with requests already driven.
   task automatic do_access(input bit keep, input logic [31:0] rd);
      int          m;
      logic [31:0] a;
      m = model_pick(m0_bus.req, m1_bus.req);
      a = (m == 1) ? m1_bus.addr : m0_bus.addr;
      #1 chk("idle_req", data_bus.req, 0);
      cyc();
      data_bus.gnt = 1'b1;
      #1;
      chk("req_high", data_bus.req, 1);
      chk("req_addr", data_bus.addr, a);
      chk("gnt_m0", m0_bus.gnt, m == 0);
      chk("gnt_m1", m1_bus.gnt, m == 1);
      last_m = m[0];
      cyc();
      data_bus.gnt = 1'b0;
      if (!keep) begin
         m0_bus.req = 1'b0;
         m1_bus.req = 1'b0;
      end
      #1 chk("resp_req", data_bus.req, 0);
      slave_rvalid(rd, m);
      cyc();
      data_bus.rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1;
      m0_bus.req = 1'b0; m0_bus.addr = '0; m0_bus.we = 1'b0; m0_bus.be = '0; m0_bus.wdata = '0;
      m1_bus.req = 1'b0; m1_bus.addr = '0; m1_bus.we = 1'b0; m1_bus.be = '0; m1_bus.wdata = '0;
      data_bus.gnt = 1'b0; data_bus.rvalid = 1'b0; data_bus.rdata = '0;

      // Reset values while inputs are active.
      cyc();
      m0_bus.req = 1'b1; m0_bus.addr = 32'h100; data_bus.gnt = 1'b1;
      #1 chk_reset_vals("rst");
      m0_bus.req = 1'b0; data_bus.gnt = 1'b0;
      do_reset();

      // Single read by m0.
      m0_bus.req = 1'b1; m0_bus.addr = 32'h100; m0_bus.we = 1'b0; m0_bus.be = 4'hF;
      do_access(1'b0, 32'hDEAD_BEEF);

      // Contention: both hold requests across four accesses.
      do_reset();
      m0_bus.req = 1'b1; m0_bus.addr = 32'h100;
      m1_bus.req = 1'b1; m1_bus.addr = 32'h400;
      for (int i = 0; i < 4; i++) begin
         do_access(1'b1, 32'hA000_0000 + i);
      end
      m0_bus.req = 1'b0; m1_bus.req = 1'b0;

      // Grant stall on a write.
      m0_bus.req = 1'b1; m0_bus.addr = 32'h200; m0_bus.we = 1'b1;
      m0_bus.be = 4'b0011; m0_bus.wdata = 32'h1234;
      #1 chk("stall_idle", data_bus.req, 0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_req", data_bus.req, 1);
         chk("stall_addr", data_bus.addr, 32'h200);
         chk("stall_we", data_bus.we, 1);
         chk("stall_be", data_bus.be, 4'b0011);
         chk("stall_wdata", data_bus.wdata, 32'h1234);
         chk("stall_nognt", m0_bus.gnt, 0);
         cyc();
      end
      data_bus.gnt = 1'b1;
      #1 chk("stall_gnt", m0_bus.gnt, 1);
      last_m = 1'b0;
      cyc();
      m0_bus.req = 1'b0; m0_bus.we = 1'b0;
      #1 chk("stall_one_gnt", m0_bus.gnt, 0);
      data_bus.gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1 chk("stall_no_rvalid", {m0_bus.rvalid, m1_bus.rvalid}, 0);
         cyc();
      end
      slave_rvalid(32'h0, 0);
      cyc();
      data_bus.rvalid = 1'b0;

      // Watchdog: granted read never answered, m1 waits behind it.
      m0_bus.req = 1'b1; m0_bus.addr = 32'h300;
      #1 chk("wd_idle", data_bus.req, 0);
      cyc();
      data_bus.gnt = 1'b1;
      #1 chk("wd_gnt", m0_bus.gnt, 1);
      last_m = 1'b0;
      cyc();
      data_bus.gnt = 1'b0; m0_bus.req = 1'b0;
      m1_bus.req = 1'b1; m1_bus.addr = 32'h500;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("wd_noreq", data_bus.req, 0);
         chk("wd_err_clear", err, 0);
         cyc();
      end
      #1 chk("wd_err_set", err, 1);
      do_access(1'b0, 32'hCAFE_F00D);

      // Abort in REQ, then reset in RESP followed by a stray rvalid.
      do_reset();
      #1 chk("abort_err_cleared", err, 0);
      m1_bus.req = 1'b1; m1_bus.addr = 32'h600;
      cyc();
      #1 chk("abort_req", data_bus.req, 1);
      m1_bus.req = 1'b0;
      #1;
      chk("abort_req_drop", data_bus.req, 0);
      chk("abort_nognt", m1_bus.gnt, 0);
      cyc();
      m0_bus.req = 1'b1; m0_bus.addr = 32'h700;
      #1 chk("abort_idle", data_bus.req, 0);
      cyc();
      #1;
      chk("abort_rearb_req", data_bus.req, 1);
      chk("abort_rearb_addr", data_bus.addr, 32'h700);
      data_bus.gnt = 1'b1;
      cyc();
      data_bus.gnt = 1'b0; m0_bus.req = 1'b0;
      rst = 1'b1;
      #1 chk_reset_vals("midrst");
      cyc();
      rst = 1'b0;
      #1;
      data_bus.rvalid = 1'b1; data_bus.rdata = 32'h5555_AAAA;
      #1 chk("stray_no_route", {m0_bus.rvalid, m1_bus.rvalid}, 0);
      cyc();
      data_bus.rvalid = 1'b0;
      #1 chk("stray_err", err, 1);

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/milano_data_arb.md
# milano_data_arb

Two-master arbiter that shares the single milano data-memory port (req/gnt/rvalid protocol) between the core LSU (master 0) and a secondary requester such as a debug module or DMA (master 1). It sits between the core's data interface and the system bus, serialises accesses with at most one outstanding transaction, and routes each response back to the master that issued it. A response watchdog recovers the port if a slave never returns `rvalid`.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`.
- `TIMEOUT`, 16, cycles spent in RESP without `rvalid` before abort; minimum 2.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m0_req_i` in 1: master 0 request.
- `m0_addr_i` in ADDR_W: master 0 address.
- `m0_we_i` in 1: master 0 write enable.
- `m0_be_i` in DATA_W/8: master 0 byte enables.
- `m0_wdata_i` in DATA_W: master 0 write data.
- `m0_gnt_o` out 1: master 0 grant.
- `m0_rvalid_o` out 1: master 0 response valid.
- `m0_rdata_o` out DATA_W: master 0 read data.
- `m1_*`: identical set of ports for master 1.
- `data_req_o` out 1: slave request.
- `data_addr_o` out ADDR_W: slave address.
- `data_we_o` out 1: slave write enable.
- `data_be_o` out DATA_W/8: slave byte enables.
- `data_wdata_o` out DATA_W: slave write data.
- `data_gnt_i` in 1: slave grant.
- `data_rvalid_i` in 1: slave response valid.
- `data_rdata_i` in DATA_W: slave read data.
- `err_o` out 1: sticky error flag, set on a stray response or a timeout.

## Operation
- FSM states: IDLE, REQ, RESP. Registers: `owner` (1 bit), `last` (1 bit), watchdog counter (`$clog2(TIMEOUT+1)` bits), `err_o`.
- **IDLE**
  - No slave request is driven.
  - If any `mN_req_i` is high, pick a winner, latch it into `owner`, and go to REQ.
- **REQ**
  - `data_req_o`, `data_addr_o`, `data_we_o`, `data_be_o` and `data_wdata_o` are the live signals of `owner`, muxed combinationally.
  - `m<owner>_gnt_o = data_gnt_i`.
  - On `data_gnt_i`: set `last <= owner`, clear the counter, go to RESP.
  - If the owner drops its request before grant: abort to IDLE next cycle. Nothing is granted.
- **RESP**
  - `data_req_o = 0`.
  - On `data_rvalid_i`: `m<owner>_rvalid_o = 1` combinationally, then go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without `rvalid`: set `err_o`, go to IDLE. No response is returned to the owner.
- Both `mN_rdata_o` carry `data_rdata_i` unconditionally. Only the owner's `rvalid` qualifies it.
- The non-owner's `gnt` and `rvalid` are always 0.
- Stray `data_rvalid_i` in IDLE or REQ is ignored for routing and sets `err_o`.
- `err_o` clears only on reset.

## Timing
- Reset values:
  - state IDLE, `owner` 0, `last` 1, counter 0, `err_o` 0.
  - All `gnt`/`rvalid` outputs 0.
  - `data_req_o` 0; slave address/write data/byte enables 0; `data_we_o` 0.
- Arbitration cost is 1 cycle. A request seen in IDLE at cycle N gives `data_req_o` high at cycle N+1.
- Grant is zero-latency from `data_gnt_i` to the owner's `gnt` (same cycle).
- Response routing is zero-latency from `data_rvalid_i` to the owner's `rvalid`. The FSM is back in IDLE the cycle after `rvalid`.
- Minimum turnaround per access: 3 cycles (IDLE → REQ → RESP with gnt and rvalid each taking one cycle).
- Reset mid-transaction returns to IDLE immediately. An outstanding response is discarded, and a later stray `rvalid` sets `err_o`.

## Configuration
- `MILANO_DATA_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous request, the master not equal to `last` wins. After reset, master 0 wins the first tie.
- Not defined: fixed priority, master 0 always wins a tie. `last` is still maintained but does not affect the choice.

## Structure
- `milano_pkg` gains:
  - `arb_state_e` (IDLE, REQ, RESP);
  - `ARB_TIMEOUT_DEF = 16`;
  - `typedef enum logic {ARB_M0, ARB_M1} arb_master_e` for `owner`/`last`.
- One sub-module, `milano_arb_pick`: a combinational winner selector taking both requests and `last`. The configuration macro is evaluated inside it.

## Test plan
- **Single access:** m0 reads 0x100; slave `gnt` at cycle 2 and `rvalid` at cycle 3 with 0xDEADBEEF → `m0_gnt_o` at cycle 2, `m0_rvalid_o` at cycle 3 with `m0_rdata_o` = 0xDEADBEEF; `m1_*` stays 0.
- **Contention:** both masters hold a request continuously for 4 accesses → with `_RR_EN`, owners alternate 0,1,0,1; without it, the order is 0,0,0,0 and m1 starves.
- **Grant stall:** `data_gnt_i` held low for 5 cycles, m0 writes 0x200 with be=4'b0011 and wdata 0x1234 → the slave signals equal m0's for all 5 cycles; one grant; no `rvalid` is returned for a write until the slave sends one.
- **Watchdog:** grant given, `rvalid` never comes → after 16 RESP cycles the FSM is in IDLE with `err_o` = 1, and a pending m1 request is then served.
- **Abort and reset:** m1 drops its request in REQ → `data_req_o` low next cycle with no grant. Assert `rst_i` in RESP, then raise a stray `rvalid` → outputs return to reset values and `err_o` = 1 after the stray `rvalid`.
